// File: rtl/a8_bus_slave_ctrl_if.sv
// A8 bus slave control bundle: monitor strobes, A8 data return path,
// internal memory request/acknowledge port and the error counters.
// The slave modport is the controller's view, the master modport is its environment.
interface a8_bus_slave_ctrl_if #(
  parameter int ADDR_BITS = 8
);
  // Strobes and synchronised bus values from the bus monitor
  logic                 a8_addr_strobe;
  logic                 a8_write_strobe;
  logic                 a8_read_strobe;
  logic                 a8_clk_falling;
  logic [15:0]          a8_addr;
  logic                 a8_rw_n;
  logic [7:0]           a8_data_in;
  // Read data return to the A8
  logic [7:0]           a8_data_out;
  logic                 a8_data_oe;
  logic                 a8_ext_sel;
  // Internal memory port
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_ack;
  logic [7:0]           mem_rdata;
  // Saturating error counters
  logic [7:0]           late_count;
  logic [7:0]           miss_count;

  modport slave (
    input  a8_addr_strobe, a8_write_strobe, a8_read_strobe, a8_clk_falling,
    input  a8_addr, a8_rw_n, a8_data_in,
    output a8_data_out, a8_data_oe, a8_ext_sel,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output late_count, miss_count
  );

  modport master (
    output a8_addr_strobe, a8_write_strobe, a8_read_strobe, a8_clk_falling,
    output a8_addr, a8_rw_n, a8_data_in,
    input  a8_data_out, a8_data_oe, a8_ext_sel,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  late_count, miss_count
  );
endinterface

// File: rtl/a8_bus_slave_ctrl.sv
// A8 bus slave cycle sequencer: decodes a memory window and converts each hit
// into one request/acknowledge transaction on the internal memory port.
// All outputs registered; mem_req rises 1 clk after the relevant strobe, and
// a8_data_oe rises 1 clk after mem_ack.
module a8_bus_slave_ctrl #(
  parameter logic [15:0] WIN_BASE  = 16'hD500,
  parameter logic [15:0] WIN_MASK  = 16'hFF00,
  parameter int          ADDR_BITS = 8
) (
  input logic                  clk,
  input logic                  a8_rst_n,
  a8_bus_slave_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_LATE, DRIVE, WR_WAIT, WR_REQ, DONE, DRAIN
  } state_t;

  state_t               state_q;
  logic [7:0]           data_out_q;
  logic                 data_oe_q;
  logic                 ext_sel_q;
  logic                 mem_req_q;
  logic                 mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic [7:0]           late_q;
  logic [7:0]           miss_q;
  logic                 hit;

  // Only meaningful together with a8_addr_strobe
  assign hit = ((bus.a8_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));

  // Bus cycle sequencer; every output is a register written here
  always_ff @(posedge clk or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      state_q     <= IDLE;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      ext_sel_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      late_q      <= 8'h00;
      miss_q      <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.a8_addr_strobe && hit) begin
            mem_addr_q <= bus.a8_addr[ADDR_BITS-1:0];
            ext_sel_q  <= 1'b1;
            if (bus.a8_rw_n) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= RD_REQ;
            end else begin
              state_q   <= WR_WAIT;
            end
          end else if (bus.a8_clk_falling) begin
            ext_sel_q <= 1'b0;
            data_oe_q <= 1'b0;
          end
        end
        RD_REQ: begin
          // An ack arriving together with the read strobe still counts as on time
          if (bus.mem_ack) begin
            data_out_q <= bus.mem_rdata;
            mem_req_q  <= 1'b0;
            if (bus.a8_clk_falling) begin
              ext_sel_q <= 1'b0;
              data_oe_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              data_oe_q <= 1'b1;
              state_q   <= DRIVE;
            end
          end else begin
            if (bus.a8_read_strobe && late_q != 8'hFF) late_q <= late_q + 8'd1;
            if (bus.a8_clk_falling) begin
              ext_sel_q <= 1'b0;
              data_oe_q <= 1'b0;
              state_q   <= DRAIN;
            end else if (bus.a8_read_strobe) begin
              state_q   <= RD_LATE;
            end
          end
        end
        RD_LATE: begin
          // Data is useless now; finish the handshake and never drive the bus
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (bus.a8_clk_falling) begin
              ext_sel_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q   <= DONE;
            end
          end else if (bus.a8_clk_falling) begin
            ext_sel_q <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= DRAIN;
          end
        end
        DRIVE, DONE: begin
          if (bus.a8_clk_falling) begin
            ext_sel_q <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WR_WAIT: begin
          // Cycle ending before the write strobe aborts without touching memory
          if (bus.a8_clk_falling) begin
            ext_sel_q <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else if (bus.a8_write_strobe) begin
            mem_wdata_q <= bus.a8_data_in;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (bus.a8_clk_falling) begin
              ext_sel_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              state_q   <= DONE;
            end
          end else if (bus.a8_clk_falling) begin
            ext_sel_q <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          // Bus cycle is over but the memory handshake must still complete
          if (bus.a8_addr_strobe && hit && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a8_data_out = data_out_q;
  assign bus.a8_data_oe  = data_oe_q;
  assign bus.a8_ext_sel  = ext_sel_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.late_count  = late_q;
  assign bus.miss_count  = miss_q;

endmodule

// File: tb/tb_a8_bus_slave_ctrl.sv
// Bench for a8_bus_slave_ctrl: directed A8 bus cycles with a programmable
// memory responder; expected memory transactions and read data are queued by
// the stimulus and popped by an independent monitor.
module tb_a8_bus_slave_ctrl;

  logic clk = 1'b0;
  logic a8_rst_n;
  always #5 clk = ~clk;

  a8_bus_slave_ctrl_if bus ();

  a8_bus_slave_ctrl dut (
    .clk      (clk),
    .a8_rst_n (a8_rst_n),
    .bus      (bus.slave)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] exp_rd[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls
  logic       resp_en = 1'b1;
  int         ack_dly = 5;
  logic [7:0] rd_val  = 8'h00;

  // Observations taken inside a bus cycle
  logic sel_mid, req_mid, oe_mid, sel_end, oe_end;

  // Monitor state
  logic mon_req_prev = 1'b0;
  logic mon_oe_prev  = 1'b0;
  txn_t mon_cur;
  txn_t mon_exp;
  logic [7:0] mon_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  function automatic logic [43:0] all_outs();
    return {bus.a8_data_out, bus.a8_data_oe, bus.a8_ext_sel, bus.mem_req, bus.mem_we,
            bus.mem_addr, bus.mem_wdata, bus.late_count, bus.miss_count};
  endfunction

  // Memory responder: ack ack_dly clk after mem_req rises
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (resp_en && bus.mem_req) begin
        repeat (ack_dly - 1) @(posedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd_val;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'hEE;
      end
    end
  end

  // Monitor: memory transactions and driven read data against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req && !mon_req_prev) begin
        mon_cur = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
        check("txn_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("mem_txn", {mon_cur.we, mon_cur.addr, (mon_cur.we ? mon_cur.wdata : 8'h00)},
                           {mon_exp.we, mon_exp.addr, (mon_exp.we ? mon_exp.wdata : 8'h00)});
        end
      end
      if (bus.mem_req && bus.mem_ack)
        check("req_stable_at_ack", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                                   {mon_cur.we, mon_cur.addr, mon_cur.wdata});
      if (bus.a8_data_oe && !mon_oe_prev) begin
        check("rd_expected", exp_rd.size() != 0, 1'b1);
        if (exp_rd.size() != 0) begin
          mon_rd = exp_rd.pop_front();
          check("rd_data", bus.a8_data_out, mon_rd);
        end
      end
      mon_req_prev = bus.mem_req;
      mon_oe_prev  = bus.a8_data_oe;
    end
  end

  // One A8 cycle: addr strobe tick 17, write 41, read 48, falling 56
  task automatic bus_cycle(input logic [15:0] addr, input logic rw_n, input logic [7:0] wd);
    bus.a8_addr = addr;
    bus.a8_rw_n = rw_n;
    for (int t = 1; t <= 56; t++) begin
      @(posedge clk);
      #1;
      bus.a8_addr_strobe  = (t == 17);
      bus.a8_write_strobe = (t == 41);
      bus.a8_read_strobe  = (t == 48);
      bus.a8_clk_falling  = (t == 56);
      bus.a8_data_in      = (t == 41) ? wd : ~wd;
      if (t == 30) sel_mid = bus.a8_ext_sel;
      if (t == 50) req_mid = bus.mem_req;
      if (t == 55) oe_mid  = bus.a8_data_oe;
    end
    @(posedge clk);
    #1;
    bus.a8_clk_falling = 1'b0;
    sel_end = bus.a8_ext_sel;
    oe_end  = bus.a8_data_oe;
  endtask

  initial begin
    a8_rst_n            = 1'b0;
    bus.a8_addr_strobe  = 1'b0;
    bus.a8_write_strobe = 1'b0;
    bus.a8_read_strobe  = 1'b0;
    bus.a8_clk_falling  = 1'b0;
    bus.a8_addr         = 16'h0000;
    bus.a8_rw_n         = 1'b1;
    bus.a8_data_in      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 44'h0);
    a8_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read hit, on time
    ack_dly = 5; rd_val = 8'h3C;
    exp_q.push_back('{we: 1'b0, addr: 8'h12, wdata: 8'h00});
    exp_rd.push_back(8'h3C);
    bus_cycle(16'hD512, 1'b1, 8'h00);
    check("rd_sel_mid", sel_mid, 1'b1);
    check("rd_oe_mid", oe_mid, 1'b1);
    check("rd_oe_end", oe_end, 1'b0);
    check("rd_sel_end", sel_end, 1'b0);
    check("rd_late_count", bus.late_count, 8'h00);

    // Ack on the same clk as the read strobe is still on time
    ack_dly = 31; rd_val = 8'hA5;
    exp_q.push_back('{we: 1'b0, addr: 8'hFF, wdata: 8'h00});
    exp_rd.push_back(8'hA5);
    bus_cycle(16'hD5FF, 1'b1, 8'h00);
    check("edge_oe_mid", oe_mid, 1'b1);
    check("edge_late_count", bus.late_count, 8'h00);

    // Write hit
    ack_dly = 2;
    exp_q.push_back('{we: 1'b1, addr: 8'hA0, wdata: 8'h7E});
    bus_cycle(16'hD5A0, 1'b0, 8'h7E);
    check("wr_sel_mid", sel_mid, 1'b1);
    check("wr_oe_mid", oe_mid, 1'b0);
    check("wr_end_req_we", {bus.mem_req, bus.mem_we, sel_end}, 3'b000);

    // Window miss
    bus_cycle(16'hD400, 1'b1, 8'h00);
    check("miss_sel_mid", sel_mid, 1'b0);
    check("miss_req_mid", req_mid, 1'b0);
    check("miss_oe_mid", oe_mid, 1'b0);

    // Late read
    ack_dly = 35; rd_val = 8'h99;
    exp_q.push_back('{we: 1'b0, addr: 8'h40, wdata: 8'h00});
    bus_cycle(16'hD540, 1'b1, 8'h00);
    check("late_count_1", bus.late_count, 8'h01);
    check("late_req_held", req_mid, 1'b1);
    check("late_oe_mid", oe_mid, 1'b0);
    check("late_end", {sel_end, bus.mem_req}, 2'b00);

    // Write ack delayed past the cycle end, next-cycle hit during drain
    ack_dly = 40;
    exp_q.push_back('{we: 1'b1, addr: 8'hB0, wdata: 8'h5A});
    bus_cycle(16'hD5B0, 1'b0, 8'h5A);
    check("drain_sel_end", sel_end, 1'b0);
    check("drain_req_held", bus.mem_req, 1'b1);
    bus_cycle(16'hD501, 1'b1, 8'h00);
    check("drain_hit_sel", sel_mid, 1'b0);
    check("miss_count_1", bus.miss_count, 8'h01);
    check("drain_done_req", bus.mem_req, 1'b0);

    // Reset while a read request is outstanding
    resp_en = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: 8'h34, wdata: 8'h00});
    @(posedge clk); #1;
    bus.a8_addr = 16'hD534; bus.a8_rw_n = 1'b1; bus.a8_addr_strobe = 1'b1;
    @(posedge clk); #1;
    bus.a8_addr_strobe = 1'b0;
    @(posedge clk); #1;
    check("rst_req_before", {bus.mem_req, bus.a8_ext_sel}, 2'b11);
    #2;
    a8_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", all_outs(), 44'h0);
    repeat (2) @(posedge clk);
    #1;
    a8_rst_n = 1'b1;
    resp_en  = 1'b1;

    // Saturation of late_count
    ack_dly = 35;
    for (int i = 1; i <= 260; i++) begin
      exp_q.push_back('{we: 1'b0, addr: 8'(i), wdata: 8'h00});
      bus_cycle({8'hD5, 8'(i)}, 1'b1, 8'h00);
      if (i == 254) check("late_count_254", bus.late_count, 8'hFE);
      if (i == 255) check("late_count_255", bus.late_count, 8'hFF);
    end
    check("late_count_sat", bus.late_count, 8'hFF);
    check("miss_after_rst", bus.miss_count, 8'h00);

    repeat (5) @(posedge clk);
    #1;
    check("txn_queue_empty", exp_q.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
